div_op: RTL and testbench

//  Iterative restoring divider for the ALU. Consumes operands from the A/Y operand stage and produces

---
 rtl/div_op.sv | 152 +++++++++++++++
 tb/tb_div_op.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_op.sv
// rtl/div_op.sv - iterative restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for signed two's-complement division; otherwise operands are unsigned.
module div_op #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic             accept;

  assign accept = (state_q == S_IDLE) && start;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;

  // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  assign mag_a   = A_reg[WIDTH-1] ? -A_reg : A_reg;
  assign mag_b   = B_reg[WIDTH-1] ? -B_reg : B_reg;
  assign fix_quo = neg_quo_q ? -dvd_q : dvd_q;
  assign fix_rem = neg_rem_q ? -part_q : part_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_quo_q <= A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
      neg_rem_q <= A_reg[WIDTH-1];
    end
  end
`else
  assign mag_a   = A_reg;
  assign mag_b   = B_reg;
  assign fix_quo = dvd_q;
  assign fix_rem = part_q;
`endif

  // Partial remainder stays below the divisor, so WIDTH bits hold it between steps.
  assign shifted = {part_q, dvd_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign diff    = shifted[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = (B_reg == '0) ? A_reg : mag_a;
          dvs_d   = mag_b;
          part_d  = '0;
          cnt_d   = CW'(WIDTH);
          dbz_d   = 1'b0;
          state_d = (B_reg == '0) ? S_ZERO : S_ITER;
        end
      end
      S_ITER: begin
        dvd_d  = {dvd_q[WIDTH-2:0], ge};
        part_d = ge ? diff : shifted[WIDTH-1:0];
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quo_d   = fix_quo;
        rem_d   = fix_rem;
        state_d = S_DONE;
      end
      S_ZERO: begin
        quo_d   = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_ITER) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_div_op.sv
// tb/tb_div_op.sv - randomized self-checking bench for div_op against an arithmetic model.
module tb_div_op;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A_reg = '0;
  logic [W-1:0] B_reg = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  div_op #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .A_reg(A_reg), .B_reg(B_reg),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Truncating division straight from the arithmetic rules.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
`ifdef DIV_SIGNED_EN
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0;
    end else begin
      q = sa / sb; r = sa % sb;
`else
    end else begin
      q = a / b; r = a % b;
`endif
    end
  endtask

  // Model: edges remaining until done becomes visible, plus pending results.
  int           m_left = 0;
  bit           m_done = 0, m_busy = 0, m_dbz = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         p_z = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_left = 0; m_done = 0; m_busy = 0; m_dbz = 0; m_q = '0; m_r = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_busy = 0; m_q = p_q; m_r = p_r; m_dbz = p_z;
      end
    end else if (start) begin
      ref_div(A_reg, B_reg, p_q, p_r, p_z);
      m_dbz  = 0;
      m_left = p_z ? 1 : W + 1;
      m_busy = !p_z;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
    end
  end

  // Issue one division; optionally pulse start again or drop clr at a given negedge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj, input int rst_at,
                         output int lat, output int busy_cnt);
    A_reg = a; B_reg = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A_reg = $urandom; B_reg = $urandom;
    lat = -1; busy_cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin lat = n; break; end
      if (n == inj) begin start = 1'b1; A_reg = $urandom; B_reg = $urandom; end
      if (n == rst_at) begin
        #2 clr = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        lat = 0;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat, bc;
    logic [W-1:0] mq, mr;
    logic mz;
    ref_div(a, b, mq, mr, mz);
    chk({nm, "_model_q"}, mq, eq);
    chk({nm, "_model_r"}, mr, er);
    run_div(a, b, 0, 0, lat, bc);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
    chk({nm, "_latency"}, lat, ez ? 32'd2 : 32'd34);
    chk({nm, "_busy_cycles"}, bc, ez ? 32'd0 : 32'd33);
    @(negedge clk);
  endtask

  initial begin
    int lat, bc, dones;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    clr = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    directed("t1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    directed("t3", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    directed("t3b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
`ifdef DIV_SIGNED_EN
    directed("t2a", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    directed("t2b", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
    directed("t4", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`else
    directed("t4", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    directed("t2u", 32'hFFFF_FF9C, 32'd7, 32'd613566742, 32'd2, 1'b0);
`endif

    // Start pulsed mid-division is ignored and produces no second done.
    run_div(32'd1000, 32'd33, 10, 0, lat, bc);
    chk("t5_q", quotient, 32'd30);
    chk("t5_r", remainder, 32'd10);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    chk("t5_no_second_done", dones, 32'd0);

    // Reset mid-division discards the result.
    run_div(32'd77, 32'd5, 0, 15, lat, bc);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    chk("t6_no_done_after_reset", dones, 32'd0);
    directed("t6_after", 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      run_div(ra, rb, $urandom_range(0, 30), 0, lat, bc);
      @(negedge clk);
    end

    // Free-running random start traffic; the model tracks acceptance.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      A_reg = $urandom;
      B_reg = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
